alu_iterative: RTL and testbench
================================

Name: alu_iterative

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code from the ALU controller, plus the two operands from the ID/EX path.
- Single-pass ops (add/sub/logic/compare/LUI) produce a registered result one cycle after acceptance.
- Shifts run bit-serially, one bit per cycle, to save area.
- Valid/ready handshakes on both sides let the pipeline control logic stall EX while a shift is in flight.

Parameters:
- DATA_WIDTH, 32: operand and result width.
- SHAMT_WIDTH, 5: shift-amount bits taken from src_b[SHAMT_WIDTH-1:0]; must equal log2(DATA_WIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and operation are valid.
- in_ready  output  1  block can accept a new op.
- operation  input  4  ALU operation code (encoding below).
- src_a  input  DATA_WIDTH  operand A (rs1 / PC).
- src_b  input  DATA_WIDTH  operand B (rs2 / immediate).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  DATA_WIDTH  ALU result; compare ops give 0 or 1.
- zero  output  1  result == 0.
- illegal_op  output  1  the completed op had an unassigned code; qualified by out_valid.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal_op=0.
- Operation encoding (fixed):
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB; 0100 XOR.
  - 0101 SRL; 0110 SLL; 0111 SRA.
  - 1000 EQ (A==B); 1010 PASSB (LUI); 1011 LT signed; 1100 GE signed; 1110 SLT signed.
  - All other codes are illegal.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^DATA_WIDTH.
  - Compares are two's-complement signed; result is zero-extended 1/0.
  - Shift amount = src_b[SHAMT_WIDTH-1:0]; upper bits of src_b are ignored.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE, when in_valid && in_ready:
  - Non-shift op: result is computed combinationally and registered; go to DONE. out_valid rises on cycle N+1.
  - Illegal op: result=0, illegal_op=1; go to DONE.
  - Shift op with shamt==0: result=src_a; go to DONE (latency 1).
  - Shift op with shamt>0: load working reg=src_a, counter=shamt, latch op kind; go to SHIFT.
- SHIFT:
  - Each cycle: working reg shifts 1 bit (SRL zero-fill, SLL zero-fill, SRA sign-fill); counter decrements.
  - When the counter reaches 0, result=working reg and go to DONE.
  - out_valid rises on cycle N+1+shamt (shamt=31 gives 32 cycles).
- DONE:
  - result, zero and illegal_op stay stable until out_ready.
  - On out_valid && out_ready, go to IDLE; in_ready=1 in the next cycle.
  - There is no same-cycle turnaround: back-to-back ops are accepted at most every 2 cycles.
- in_valid while busy is ignored; upstream must hold its inputs (standard valid/ready).
- Inputs are sampled only at acceptance; later changes to src_a, src_b or operation do not affect an op in flight.
- Reset asserted mid-shift or in DONE: immediate return to the reset values; the in-flight op is discarded with no out_valid.
- zero is derived from the registered result, so it is valid whenever out_valid=1.
- illegal_op is cleared on every legal completion.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e for the codes above;
  - typedef enum state_e {IDLE, SHIFT, DONE};
  - a function is_shift(alu_op_e).
- Shared with the ALU controller, which should drive alu_op_e.
- One combinational sub-module, alu_single_cycle (op, a, b -> y, illegal), covers all non-shift ops.
- The FSM and serial shifter stay in alu_iterative.

Test Plan:
- ADD 0x7FFFFFFF+1 (op 0010) with out_ready=1 -> out_valid on cycle N+1, result=0x80000000, zero=0.
- SUB 5-5 (op 0011) -> result=0, zero=1; BLT (op 1011) A=-1, B=1 -> result=1; BGE (op 1100) same operands -> result=0.
- SRA (op 0111) A=0x80000000, B=0xFFFFFFE4 (shamt=4) -> in_ready=0 for 4 shift cycles, result=0xF8000000 on cycle N+5; then SRL with same A, shamt=31 -> result=1 on cycle N+32.
- SLL (op 0110) with shamt=0, A=0x1234 -> latency 1, result=0x1234.
- Back-pressure: hold out_ready=0 for 10 cycles after a result -> result stable, in_ready=0, and a new in_valid is ignored; release -> IDLE, next op accepted.
- Illegal op 1111 -> result=0, illegal_op=1. Then assert rst_n=0 during a shamt=20 shift -> out_valid never pulses for that op and all outputs return to their reset values immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding (also driven by the ALU controller),
// FSM states and the shift-class helper.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SLL   = 4'b0110,
        OP_SRA   = 4'b0111,
        OP_EQ    = 4'b1000,
        OP_PASSB = 4'b1010,
        OP_LT    = 4'b1011,
        OP_GE    = 4'b1100,
        OP_SLT   = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    function automatic logic is_shift(alu_op_e op);
        return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_single_cycle.sv
// Combinational datapath for every non-shift operation; unassigned codes
// yield zero with illegal raised.
module alu_single_cycle
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  alu_op_e               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  illegal
);

    logic lt;

    assign lt = $signed(a) < $signed(b);

    always_comb begin
        y       = '0;
        illegal = 1'b0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
            OP_XOR:   y = a ^ b;
            OP_EQ:    y = DATA_WIDTH'(a == b);
            OP_PASSB: y = b;
            OP_LT:    y = DATA_WIDTH'(lt);
            OP_SLT:   y = DATA_WIDTH'(lt);
            OP_GE:    y = DATA_WIDTH'(!lt);
            // shifts are executed serially by the parent
            OP_SRL, OP_SLL, OP_SRA: y = '0;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-pass ops complete in one cycle, shifts run one
// bit per cycle; valid/ready on both sides.
module alu_iterative
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  illegal_op
);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
    alu_op_e                 shop_q, shop_d;

    alu_op_e                 op_in;
    logic [SHAMT_WIDTH-1:0]  shamt_in;
    logic [DATA_WIDTH-1:0]   sc_y;
    logic                    sc_illegal;
    logic [DATA_WIDTH-1:0]   work_step;

    assign op_in    = alu_op_e'(operation);
    assign shamt_in = src_b[SHAMT_WIDTH-1:0];

    alu_single_cycle #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_single (
        .op      (op_in),
        .a       (src_a),
        .b       (src_b),
        .y       (sc_y),
        .illegal (sc_illegal)
    );

    always_comb begin
        case (shop_q)
            OP_SLL:  work_step = {work_q[DATA_WIDTH-2:0], 1'b0};
            OP_SRA:  work_step = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
            default: work_step = {1'b0, work_q[DATA_WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            work_q    <= '0;
            cnt_q     <= '0;
            shop_q    <= OP_SRL;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            shop_q    <= shop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        shop_d    = shop_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift(op_in)) begin
                        if (shamt_in == '0) begin
                            result_d  = src_a;
                            illegal_d = 1'b0;
                            state_d   = DONE;
                        end else begin
                            work_d  = src_a;
                            cnt_d   = shamt_in;
                            shop_d  = op_in;
                            state_d = SHIFT;
                        end
                    end else begin
                        result_d  = sc_y;
                        illegal_d = sc_illegal;
                        state_d   = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q - 1'b1;
                // last step: publish the shifted value directly, skipping a cycle
                if (cnt_q == SHAMT_WIDTH'(1)) begin
                    result_d  = work_step;
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        result     = result_q;
        zero       = (result_q == '0);
        illegal_op = illegal_q;
    end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative with an operand-level reference model and
// an in-order scoreboard of accepted operations.
module tb_alu_iterative;

    typedef struct packed {
        logic        ill;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_iterative #(
        .DATA_WIDTH  (32),
        .SHAMT_WIDTH (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t       e;
        logic [4:0] sh;
        sh    = b[4:0];
        e.ill = 1'b0;
        e.res = 32'd0;
        case (op)
            4'h0: e.res = a & b;
            4'h1: e.res = a | b;
            4'h2: e.res = a + b;
            4'h3: e.res = a - b;
            4'h4: e.res = a ^ b;
            4'h5: e.res = a >> sh;
            4'h6: e.res = a << sh;
            4'h7: e.res = 32'($signed(a) >>> sh);
            4'h8: e.res = {31'd0, a == b};
            4'hA: e.res = b;
            4'hB: e.res = {31'd0, $signed(a) < $signed(b)};
            4'hC: e.res = {31'd0, $signed(a) >= $signed(b)};
            4'hE: e.res = {31'd0, $signed(a) < $signed(b)};
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && in_valid && in_ready)
            sb.push_back(model(operation, src_a, src_b));
        if (rst_n === 1'b1 && out_valid && out_ready) begin
            check("sb_pending", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", result, e.res);
                check("sb_zero", 32'(zero), 32'(e.res == 32'd0));
                check("sb_illegal", 32'(illegal_op), 32'(e.ill));
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd1);
        check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
    endtask

    // Drive an op and hold it until accepted; inputs are scrambled afterwards.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        operation = op;
        src_a     = a;
        src_b     = b;
        in_valid  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operation = 4'($urandom);
        src_a     = $urandom;
        src_b     = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res,
                             input logic exp_ill);
        int lat;
        lat = 1;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 64) break;
            check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, 32'(zero), 32'(exp_res == 32'd0));
        check({tag, "_illegal"}, 32'(illegal_op), 32'(exp_ill));
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operation = 4'h0;
        src_a     = 32'd0;
        src_b     = 32'd0;
        #12;
        check_reset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(4'h2, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_done("add_ovf", 1, 32'h8000_0000, 1'b0);
        issue(4'h3, 32'd5, 32'd5);
        wait_done("sub_zero", 1, 32'h0, 1'b0);
        issue(4'hB, 32'hFFFF_FFFF, 32'd1);
        wait_done("lt_neg", 1, 32'd1, 1'b0);
        issue(4'hC, 32'hFFFF_FFFF, 32'd1);
        wait_done("ge_neg", 1, 32'd0, 1'b0);
        issue(4'hE, 32'd3, 32'hFFFF_FFFE);
        wait_done("slt_pos", 1, 32'd0, 1'b0);
        issue(4'h8, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        wait_done("eq", 1, 32'd1, 1'b0);
        issue(4'h0, 32'hF0F0_FF00, 32'h0FF0_F0F0);
        wait_done("and", 1, 32'h00F0_F000, 1'b0);
        issue(4'h1, 32'hF000_0000, 32'h0000_000F);
        wait_done("or", 1, 32'hF000_000F, 1'b0);
        issue(4'h4, 32'hAAAA_5555, 32'hFFFF_0000);
        wait_done("xor", 1, 32'h5555_5555, 1'b0);
        issue(4'hA, 32'h1111_1111, 32'hABCD_E000);
        wait_done("passb", 1, 32'hABCD_E000, 1'b0);

        issue(4'h7, 32'h8000_0000, 32'hFFFF_FFE4);
        wait_done("sra4", 5, 32'hF800_0000, 1'b0);
        issue(4'h5, 32'h8000_0000, 32'h0000_001F);
        wait_done("srl31", 32, 32'h0000_0001, 1'b0);
        issue(4'h6, 32'h0000_1234, 32'hFFFF_FFE0);
        wait_done("sll0", 1, 32'h0000_1234, 1'b0);
        issue(4'h6, 32'h8000_1234, 32'h0000_0008);
        wait_done("sll8", 9, 32'h0012_3400, 1'b0);
        issue(4'h7, 32'h4000_0000, 32'h0000_0001);
        wait_done("sra1_pos", 2, 32'h2000_0000, 1'b0);

        // back-pressure: result must hold and new requests must be ignored
        out_ready = 1'b0;
        issue(4'h2, 32'd3, 32'd4);
        wait_done("bp", 1, 32'd7, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            operation = 4'h4;
            src_a     = $urandom;
            src_b     = $urandom;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result", result, 32'd7);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        issue(4'h4, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
        wait_done("after_bp", 1, 32'hF0F0_F0F0, 1'b0);

        issue(4'hF, 32'h1234_5678, 32'h1);
        wait_done("illegal_f", 1, 32'd0, 1'b1);
        issue(4'h9, 32'h1, 32'h1);
        wait_done("illegal_9", 1, 32'd0, 1'b1);
        issue(4'h2, 32'd1, 32'd1);
        wait_done("illegal_clear", 1, 32'd2, 1'b0);

        // reset during a long shift discards the op
        issue(4'h5, 32'hFFFF_FFFF, 32'd20);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("midshift_rst");
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_out_valid", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        issue(4'h1, 32'h0000_00F0, 32'h0000_000F);
        wait_done("post_rst", 1, 32'h0000_00FF, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
